// File: rtl/cache_mem_arbiter.sv
// Purpose : shares one burst memory port between icache read, dcache read and dcache write.
// Latency : one cycle from request to grant; beats/responses pass through with no added latency.
// Backpr. : memory handshakes reach only the owner; other channels see zeros and keep valid held.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   i_r*                          icache read channel (request in, beats out)
//   d_r*                          dcache read channel (request in, beats out)
//   d_w*, d_b*                    dcache write channel (request/beats in, accept/response out)
//   m_r*, m_w*, m_b*              memory-side burst port
//   grant                         current owner: 0 none, 1 icache, 2 dcache read, 3 dcache write
//   len_err                       sticky flag: a burst ended on a beat count that disagreed with len
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    // icache read
    input  logic                  i_rvalid,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic [2:0]            i_rsize,
    input  logic [LEN_WIDTH-1:0]  i_rlen,
    output logic                  i_rready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rlast,
    // dcache read
    input  logic                  d_rvalid,
    input  logic [ADDR_WIDTH-1:0] d_raddr,
    input  logic [2:0]            d_rsize,
    input  logic [LEN_WIDTH-1:0]  d_rlen,
    output logic                  d_rready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rlast,
    // dcache write
    input  logic                  d_wvalid,
    input  logic [ADDR_WIDTH-1:0] d_waddr,
    input  logic [2:0]            d_wsize,
    input  logic [LEN_WIDTH-1:0]  d_wlen,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_wstrb,
    input  logic                  d_wlast,
    output logic                  d_wready,
    output logic                  d_bvalid,
    input  logic                  d_bready,
    // memory read
    output logic                  m_rvalid,
    output logic [ADDR_WIDTH-1:0] m_raddr,
    output logic [2:0]            m_rsize,
    output logic [LEN_WIDTH-1:0]  m_rlen,
    input  logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rlast,
    // memory write
    output logic                  m_wvalid,
    output logic [ADDR_WIDTH-1:0] m_waddr,
    output logic [2:0]            m_wsize,
    output logic [LEN_WIDTH-1:0]  m_wlen,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    // status
    output logic [1:0]            grant,
    output logic                  len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_e;

    localparam int CNT_W = LEN_WIDTH + 1;

    state_e                state_q,      state_d;
    logic [1:0]            grant_q,      grant_d;
    logic                  len_err_q,    len_err_d;
    logic                  last_was_d_q, last_was_d_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [2:0]            size_q,       size_d;
    logic [LEN_WIDTH-1:0]  len_q,        len_d;

    logic                  beat;
    logic                  beat_last;
    logic                  term;

    // Next-state: arbitration, beat counting and burst termination.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        len_err_d    = len_err_q;
        last_was_d_d = last_was_d_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        len_d        = len_q;
        beat         = 1'b0;
        beat_last    = 1'b0;
        term         = 1'b0;

        case (state_q)
            IDLE: begin
                // After a dcache burst a waiting icache goes first so it cannot be starved.
                if (last_was_d_q && i_rvalid) begin
                    state_d = I_RD;
                    grant_d = 2'd1;
                    addr_d  = i_raddr;
                    size_d  = i_rsize;
                    len_d   = i_rlen;
                end else if (d_wvalid) begin
                    state_d = D_WR;
                    grant_d = 2'd3;
                    addr_d  = d_waddr;
                    size_d  = d_wsize;
                    len_d   = d_wlen;
                end else if (d_rvalid) begin
                    state_d = D_RD;
                    grant_d = 2'd2;
                    addr_d  = d_raddr;
                    size_d  = d_rsize;
                    len_d   = d_rlen;
                end else if (i_rvalid) begin
                    state_d = I_RD;
                    grant_d = 2'd1;
                    addr_d  = i_raddr;
                    size_d  = i_rsize;
                    len_d   = i_rlen;
                end
                cnt_d = '0;
            end
            I_RD, D_RD: begin
                beat      = m_rready;
                beat_last = m_rlast;
                term      = m_rready && m_rlast;
            end
            D_WR: begin
                beat      = d_wvalid && m_wready;
                beat_last = d_wlast;
                // Write ownership lasts until the response handshake, not the last data beat.
                term      = m_bvalid && d_bready;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'd0;
            end
        endcase

        if (beat) begin
            // cnt_q is the number of beats already seen, so the last beat must find cnt_q == len.
            if ((beat_last && (cnt_q != {1'b0, len_q})) || (cnt_q > {1'b0, len_q})) begin
                len_err_d = 1'b1;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (term) begin
            state_d      = IDLE;
            grant_d      = 2'd0;
            cnt_d        = '0;
            last_was_d_d = (state_q != I_RD);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            len_err_q    <= 1'b0;
            last_was_d_q <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            len_err_q    <= len_err_d;
            last_was_d_q <= last_was_d_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            len_q        <= len_d;
        end
    end

    // Routing: descriptor fields come from the grant-time latch, everything else is live.
    always_comb begin
        i_rready = 1'b0;
        i_rdata  = '0;
        i_rlast  = 1'b0;
        d_rready = 1'b0;
        d_rdata  = '0;
        d_rlast  = 1'b0;
        d_wready = 1'b0;
        d_bvalid = 1'b0;
        m_rvalid = 1'b0;
        m_raddr  = '0;
        m_rsize  = '0;
        m_rlen   = '0;
        m_wvalid = 1'b0;
        m_waddr  = '0;
        m_wsize  = '0;
        m_wlen   = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_wlast  = 1'b0;
        m_bready = 1'b0;

        case (state_q)
            I_RD: begin
                m_rvalid = i_rvalid;
                m_raddr  = addr_q;
                m_rsize  = size_q;
                m_rlen   = len_q;
                i_rready = m_rready;
                i_rdata  = m_rdata;
                i_rlast  = m_rlast;
            end
            D_RD: begin
                m_rvalid = d_rvalid;
                m_raddr  = addr_q;
                m_rsize  = size_q;
                m_rlen   = len_q;
                d_rready = m_rready;
                d_rdata  = m_rdata;
                d_rlast  = m_rlast;
            end
            D_WR: begin
                m_wvalid = d_wvalid;
                m_waddr  = addr_q;
                m_wsize  = size_q;
                m_wlen   = len_q;
                m_wdata  = d_wdata;
                m_wstrb  = d_wstrb;
                m_wlast  = d_wlast;
                d_wready = m_wready;
                d_bvalid = m_bvalid;
                m_bready = d_bready;
            end
            default: begin
            end
        endcase
    end

    assign grant   = grant_q;
    assign len_err = len_err_q;

endmodule
